// File: rtl/uphi_rebuild_mc.sv
// Table-driven sweep generator: derives base/step from an offset/gap configuration,
// then reads one table entry per sample and streams it REPEAT times with edge blanking.
module uphi_rebuild_mc #(
    parameter int               VOL_W       = 8,
    parameter int               ADDR_W      = 13,
    parameter int               TABLE_DEPTH = 8192,
    parameter int               OFS_W       = 8,
    parameter int               GAP_W       = 12,
    parameter int               VOL_NUM     = 720,
    parameter int               REPEAT      = 4,
    parameter logic [VOL_W-1:0] BLANK       = 8'hFF
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         cfg_valid,
    input  logic signed [OFS_W-1:0]      cfg_offset,
    input  logic signed [GAP_W-1:0]      cfg_gap,
    input  logic                         cfg_mirror,
    input  logic                         cfg_dir,
    input  logic                         start,
    input  logic                         abort,
    output logic                         mem_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [VOL_W-1:0]             mem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [VOL_W-1:0]             out_data,
    output logic [$clog2(VOL_NUM)-1:0]   out_idx,
    output logic [$clog2(REPEAT):0]      out_rep,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W = $clog2(VOL_NUM);
    localparam int REP_W = $clog2(REPEAT) + 1;
    localparam int PRD_W = OFS_W + GAP_W;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(VOL_NUM - 1);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT - 1);
    localparam logic signed [31:0] TD_S    = 32'(TABLE_DEPTH);
    localparam logic signed [31:0] VN_S    = 32'(VOL_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ARMED,
        S_FETCH,
        S_CAPT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                    state_q;
    logic signed [OFS_W-1:0]   ofs_q;
    logic signed [GAP_W-1:0]   gap_q;
    logic                      mirror_q;
    logic                      dir_q;
    logic [ADDR_W-1:0]         base_q;
    logic signed [GAP_W:0]     step_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [IDX_W-1:0]          idx_q;
    logic [REP_W-1:0]          rep_q;
    logic                      mem_en_q;
    logic                      out_valid_q;
    logic [VOL_W-1:0]          out_data_q;
    logic                      busy_q;
    logic                      done_q;

    logic signed [PRD_W-1:0]   prod_c;
    logic signed [31:0]        base_c;
    logic signed [GAP_W:0]     gap_abs_c;
    logic signed [GAP_W:0]     step_d;
    logic signed [31:0]        sum_c;
    logic [ADDR_W-1:0]         base_d;
    logic [ADDR_W-1:0]         addr_d;
    logic signed [31:0]        ofs_c;
    logic signed [31:0]        idx_c;
    logic                      blank_c;

    always_comb begin
        prod_c = PRD_W'(ofs_q) * PRD_W'(gap_q);
        base_c = (32'sd0 - 32'(prod_c)) % TD_S;
        if (base_c < 0) begin
            base_c = base_c + TD_S;
        end
        base_d = ADDR_W'(base_c);

        gap_abs_c = gap_q[GAP_W-1] ? -(GAP_W+1)'(gap_q) : (GAP_W+1)'(gap_q);
        step_d    = (mirror_q != dir_q) ? gap_abs_c : -gap_abs_c;

        // Single wrap is enough because |step| < TABLE_DEPTH and addr is in range.
        sum_c = $signed(32'(addr_q)) + 32'(step_q);
        if (sum_c < 0) begin
            sum_c = sum_c + TD_S;
        end else if (sum_c >= TD_S) begin
            sum_c = sum_c - TD_S;
        end
        addr_d = ADDR_W'(sum_c);

        // Negative offsets blank the tail; |offset| >= VOL_NUM falls out as blank-all.
        ofs_c = 32'(ofs_q);
        idx_c = $signed(32'(idx_q));
        if (ofs_c > 0) begin
            blank_c = idx_c < ofs_c;
        end else if (ofs_c < 0) begin
            blank_c = idx_c >= (VN_S + ofs_c);
        end else begin
            blank_c = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            ofs_q       <= '0;
            gap_q       <= '0;
            mirror_q    <= 1'b0;
            dir_q       <= 1'b0;
            base_q      <= '0;
            step_q      <= '0;
            addr_q      <= '0;
            idx_q       <= '0;
            rep_q       <= '0;
            mem_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                state_q     <= S_IDLE;
                mem_en_q    <= 1'b0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cfg_valid) begin
                            ofs_q    <= cfg_offset;
                            gap_q    <= cfg_gap;
                            mirror_q <= cfg_mirror;
                            dir_q    <= cfg_dir;
                            busy_q   <= 1'b1;
                            state_q  <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        base_q  <= base_d;
                        step_q  <= step_d;
                        state_q <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (start) begin
                            addr_q   <= base_q;
                            idx_q    <= '0;
                            rep_q    <= '0;
                            mem_en_q <= 1'b1;
                            state_q  <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        mem_en_q <= 1'b0;
                        state_q  <= S_CAPT;
                    end
                    S_CAPT: begin
                        out_data_q  <= blank_c ? BLANK : mem_rdata;
                        out_valid_q <= 1'b1;
                        state_q     <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (out_valid_q && out_ready) begin
                            if (rep_q == REP_LAST) begin
                                out_valid_q <= 1'b0;
                                if (idx_q == IDX_LAST) begin
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end else begin
                                    rep_q    <= '0;
                                    idx_q    <= idx_q + 1'b1;
                                    addr_q   <= addr_d;
                                    mem_en_q <= 1'b1;
                                    state_q  <= S_FETCH;
                                end
                            end else begin
                                rep_q <= rep_q + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_addr  = addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign out_rep   = rep_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_uphi_rebuild_mc.sv
// Scoreboard bench for uphi_rebuild_mc: a table model pushes expected addresses and beats
// at start; a negedge monitor pops and compares them as the DUT issues reads and beats.
module tb_uphi_rebuild_mc;

    localparam int TD = 8192;
    localparam int VN = 720;
    localparam int RP = 4;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               cfg_valid;
    logic signed [7:0]  cfg_offset;
    logic signed [11:0] cfg_gap;
    logic               cfg_mirror;
    logic               cfg_dir;
    logic               start;
    logic               abort;
    logic               mem_en;
    logic [12:0]        mem_addr;
    logic [7:0]         mem_rdata = '0;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;
    logic [9:0]         out_idx;
    logic [2:0]         out_rep;
    logic               busy;
    logic               done;

    always #5 clk_in = ~clk_in;

    uphi_rebuild_mc dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .cfg_valid  (cfg_valid),
        .cfg_offset (cfg_offset),
        .cfg_gap    (cfg_gap),
        .cfg_mirror (cfg_mirror),
        .cfg_dir    (cfg_dir),
        .start      (start),
        .abort      (abort),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_rep    (out_rep),
        .busy       (busy),
        .done       (done)
    );

    // Table contents never reach 8'hFF, so a blanked beat is always distinguishable.
    always @(posedge clk_in) begin
        if (mem_en) mem_rdata <= 8'(32'(mem_addr) % 255);
    end

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] idx;
        logic [2:0] rep;
    } beat_t;

    beat_t       exp_beat_q[$];
    logic [12:0] exp_addr_q[$];
    beat_t       mon_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -10;
    int last_hs_cyc = 0;
    int n_beats  = 0;
    int c_off, c_gap;
    logic c_mir, c_dir;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int m_base();
        int b = -(c_off * c_gap);
        while (b < 0) b += TD;
        while (b >= TD) b -= TD;
        return b;
    endfunction

    function automatic int m_addr(input int i);
        int st = (c_gap < 0) ? -c_gap : c_gap;
        int a;
        if (c_mir == c_dir) st = -st;
        a = (m_base() + i * st) % TD;
        if (a < 0) a += TD;
        return a;
    endfunction

    function automatic logic [7:0] m_data(input int i);
        logic blank;
        if (c_off > 0)      blank = (i < c_off);
        else if (c_off < 0) blank = (i >= VN + c_off);
        else                blank = 1'b0;
        return blank ? 8'hFF : 8'(m_addr(i) % 255);
    endfunction

    always @(negedge clk_in) begin
        cyc++;
        if (mem_en) begin
            chk_eq("sb_addr_pending", 32'(exp_addr_q.size() > 0), 1);
            if (exp_addr_q.size() > 0) chk_eq("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            chk_eq("valid_in_fetch", 32'(out_valid), 0);
        end
        if (out_valid && out_ready) begin
            n_beats++;
            last_hs_cyc = cyc;
            chk_eq("sb_beat_pending", 32'(exp_beat_q.size() > 0), 1);
            if (exp_beat_q.size() > 0) begin
                mon_b = exp_beat_q.pop_front();
                chk_eq("beat_data", 32'(out_data), 32'(mon_b.data));
                chk_eq("beat_idx",  32'(out_idx),  32'(mon_b.idx));
                chk_eq("beat_rep",  32'(out_rep),  32'(mon_b.rep));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic flush_sb();
        exp_beat_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk_eq({tag, "_mem_en"},    32'(mem_en),    0);
        chk_eq({tag, "_out_valid"}, 32'(out_valid), 0);
        chk_eq({tag, "_busy"},      32'(busy),      0);
        chk_eq({tag, "_done"},      32'(done),      0);
        chk_eq({tag, "_mem_addr"},  32'(mem_addr),  0);
        chk_eq({tag, "_out_data"},  32'(out_data),  0);
        chk_eq({tag, "_out_idx"},   32'(out_idx),   0);
        chk_eq({tag, "_out_rep"},   32'(out_rep),   0);
    endtask

    // Leaves the DUT in ARMED at posedge+1.
    task automatic do_cfg(input int off, input int gap, input logic mir, input logic dir);
        c_off = off; c_gap = gap; c_mir = mir; c_dir = dir;
        @(posedge clk_in); #1;
        cfg_offset = 8'(off);
        cfg_gap    = 12'(gap);
        cfg_mirror = mir;
        cfg_dir    = dir;
        cfg_valid  = 1'b1;
        @(posedge clk_in); #1;
        cfg_valid  = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic do_start();
        flush_sb();
        n_beats = 0;
        for (int i = 0; i < VN; i++) begin
            exp_addr_q.push_back(13'(m_addr(i)));
            for (int r = 0; r < RP; r++)
                exp_beat_q.push_back('{data: m_data(i), idx: 10'(i), rep: 3'(r)});
        end
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk_in); #1;
            k++;
        end
        chk_eq({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
        repeat (3) @(posedge clk_in);
        #1;
        chk_eq({tag, "_done_once"},   32'(done_cnt - d0), 1);
        chk_eq({tag, "_done_timing"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
        chk_eq({tag, "_beats"},       32'(n_beats), VN * RP);
        chk_eq({tag, "_sb_beats_left"}, 32'(exp_beat_q.size()), 0);
        chk_eq({tag, "_sb_addr_left"},  32'(exp_addr_q.size()), 0);
        chk_eq({tag, "_busy_after"},  32'(busy), 0);
    endtask

    task automatic wait_beat(input int idx, input int rep, input int budget, input string tag);
        logic found = 1'b0;
        int   k     = 0;
        while (!found && k < budget) begin
            @(posedge clk_in); #1;
            k++;
            found = out_valid && (32'(out_idx) == idx) && (32'(out_rep) == rep);
        end
        chk_eq(tag, 32'(found), 1);
    endtask

    initial begin
        int d0;
        rst_in = 1'b1; cfg_valid = 1'b0; cfg_offset = '0; cfg_gap = '0;
        cfg_mirror = 1'b0; cfg_dir = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk_in);
        #2;
        chk_rst_outputs("init");
        rst_in = 1'b0;

        do_cfg(0, 1, 1'b1, 1'b0);
        do_start();
        wait_done(5000, "s1");

        do_cfg(3, 2, 1'b1, 1'b0);
        do_start();
        wait_done(5000, "s2");

        do_cfg(-2, 5, 1'b0, 1'b0);
        do_start();
        wait_done(5000, "s3");

        // Backpressure at idx 5 / rep 2, then abort at idx 100.
        do_cfg(1, -7, 1'b1, 1'b1);
        do_start();
        wait_beat(5, 2, 200, "stall_reach");
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            chk_eq("stall_data",  32'(out_data),  32'(m_data(5)));
            chk_eq("stall_idx",   32'(out_idx),   5);
            chk_eq("stall_rep",   32'(out_rep),   2);
            chk_eq("stall_valid", 32'(out_valid), 1);
            chk_eq("stall_mem_en", 32'(mem_en),   0);
        end
        @(posedge clk_in); #1;
        out_ready = 1'b1;
        wait_beat(100, 0, 1000, "abort_reach");
        d0 = done_cnt;
        abort = 1'b1;
        @(posedge clk_in); #1;
        abort = 1'b0;
        chk_eq("abort_busy",      32'(busy),      0);
        chk_eq("abort_out_valid", 32'(out_valid), 0);
        chk_eq("abort_mem_en",    32'(mem_en),    0);
        flush_sb();
        repeat (10) @(posedge clk_in);
        #1;
        chk_eq("abort_no_done", 32'(done_cnt - d0), 0);
        chk_eq("abort_idle",    32'(busy), 0);

        do_cfg(1, -7, 1'b1, 1'b1);
        do_start();
        wait_done(5000, "replay");

        // start and abort together in ARMED: abort wins, no read is issued.
        do_cfg(0, 1, 1'b1, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        abort = 1'b0;
        chk_eq("abort_start_busy", 32'(busy), 0);
        repeat (5) @(posedge clk_in);
        #1;
        chk_eq("abort_start_idle", 32'(busy), 0);

        // Asynchronous reset mid-sweep, then start without configuration.
        do_cfg(0, 1, 1'b1, 1'b0);
        do_start();
        wait_beat(50, 0, 600, "rst_reach");
        #2;
        rst_in = 1'b1;
        #1;
        chk_rst_outputs("midrst");
        flush_sb();
        repeat (2) @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        repeat (10) @(posedge clk_in);
        #1;
        chk_eq("rst_start_ignored_busy",  32'(busy),      0);
        chk_eq("rst_start_ignored_valid", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uphi_rebuild_mc.md
UPHI_REBUILD_MC -- requirements
Module: uphi_rebuild_mc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- VOL_W, 8, sample width.
- ADDR_W, 13, table address width.
- TABLE_DEPTH, 8192, table entries; must be ≤ 2^ADDR_W.
- OFS_W, 8, signed offset width.
- GAP_W, 12, signed gap width; |gap| < TABLE_DEPTH.
- VOL_NUM, 720, samples per sweep.
- REPEAT, 4, beats per sample; must be ≥ 1.
- BLANK, 8'hFF, value output for blanked indices.
REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- clk_in, in, 1, clock.
- rst_in, in, 1, async active-high reset.
- cfg_valid, in, 1, configuration strobe.
- cfg_offset, in, OFS_W signed, offset.
- cfg_gap, in, GAP_W signed, address gap.
- cfg_mirror, in, 1, mirror select.
- cfg_dir, in, 1, direction (opa sign).
- start, in, 1, begin sweep.
- abort, in, 1, cancel sweep.
- mem_en, out, 1, table read enable.
- mem_addr, out, ADDR_W, table address.
- mem_rdata, in, VOL_W, table data, valid 1 cycle after mem_en.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accept.
- out_data, out, VOL_W, sample value.
- out_idx, out, clog2(VOL_NUM), sample index.
- out_rep, out, clog2(REPEAT)+1, beat within sample.
- busy, out, 1, high whenever not IDLE.
- done, out, 1, one-cycle completion pulse.

Function
REQ-004 The state machine SHALL have the states IDLE, CALC, ARMED, FETCH, CAPT, STREAM and DONE.
REQ-005 In IDLE, cfg_valid SHALL latch all cfg_* inputs and move to CALC; cfg_valid outside IDLE SHALL be ignored.
REQ-006 CALC SHALL take one cycle:
- base = (-(offset*gap)) mod TABLE_DEPTH, in [0, TABLE_DEPTH-1], using a full-width signed product.
- step = +|gap| when cfg_mirror != cfg_dir, else -|gap|.
- Next state ARMED.
REQ-007 In ARMED, start SHALL load addr=base, idx=0, rep=0 and go to FETCH; start in any other state SHALL be ignored.
REQ-008 FETCH SHALL drive mem_en=1 with mem_addr=addr for exactly one cycle and go to CAPT; mem_en SHALL be 0 in all other states.
REQ-009 CAPT SHALL load out_data (mem_rdata, or BLANK if idx is blanked), assert out_valid and go to STREAM.
REQ-010 Blanking SHALL be decided per idx:
- offset > 0: idx < offset is blanked.
- offset < 0: idx ≥ VOL_NUM-|offset| is blanked.
- offset = 0: nothing is blanked.
- |offset| ≥ VOL_NUM: every idx is blanked.
REQ-011 In STREAM, each out_valid&&out_ready handshake SHALL increment rep.
- When rep == REPEAT-1 and idx < VOL_NUM-1: clear rep, increment idx, update addr, go to FETCH.
- When rep == REPEAT-1 and idx == VOL_NUM-1: go to DONE.
REQ-012 The address update SHALL be addr_next = addr+step, plus TABLE_DEPTH if the result is negative, minus TABLE_DEPTH if the result is ≥ TABLE_DEPTH.
REQ-013 While out_valid=1 and out_ready=0, out_data, out_idx and out_rep SHALL stay stable and no mem_en SHALL be issued.
REQ-014 out_valid SHALL be 0 in FETCH, CAPT and DONE.
REQ-015 DONE SHALL assert done for one cycle and return to IDLE; the latched configuration SHALL be retained, so a new start requires a new cfg_valid.
REQ-016 abort in any non-IDLE state SHALL return the block to IDLE on the next edge with out_valid=0, mem_en=0 and no done pulse.
REQ-017 If abort and start arrive together, abort SHALL win.
REQ-018 If abort and the final handshake arrive together, abort SHALL win and done SHALL stay 0.
REQ-019 One sample SHALL take REPEAT+2 cycles at full throughput (FETCH, CAPT, then REPEAT beats).

Reset
REQ-020 While rst_in=1, the block SHALL immediately (asynchronously) hold:
- state IDLE;
- mem_en, out_valid, busy and done at 0;
- mem_addr, out_data, out_idx and out_rep at 0;
- the latched configuration cleared.
REQ-021 Reset asserted mid-sweep SHALL discard the sweep; after release the block SHALL require cfg_valid before start.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- offset=0, gap=1, mirror=1, dir=0, out_ready=1 → mem_addr 0,1,…,719; 2880 beats; out_rep cycles 0..3; done exactly once, 1 cycle after the last beat; no BLANK data.
- offset=3, gap=2, mirror=1, dir=0 → base 8186; addresses 8186, 8188, 8190, 0, 2…; idx 0..2 output 8'hFF.
- offset=-2, gap=5, mirror=0, dir=0 → base 10; addresses 10, 5, 0, 8187…; idx 718 and 719 output 8'hFF.
- out_ready low for 3 cycles at idx=5, rep=2 → out_data, out_idx and out_rep stable; mem_en=0 throughout; the stream resumes without loss.
- abort at idx=100 → busy=0 and out_valid=0 next cycle, no done; a subsequent cfg_valid+start replays from idx 0.
- rst_in pulsed at idx=50 → all outputs 0 immediately; start before cfg_valid is ignored.
